// File: rtl/bp_xui_mem_pkg.sv
// ---------------------------------------------------------------------------
// bp_xui_mem_pkg
//   Shared types and default sizes for the behavioural XUI memory responder.
//   app_cmd_e carries the same encoding as the DMC user-interface command
//   field (write = 0, read = 1) so traffic from bp_burst_to_xui is understood
//   unchanged. Any other opcode is treated as a protocol error by the block.
// ---------------------------------------------------------------------------
package bp_xui_mem_pkg;

  // XUI command opcodes.
  typedef enum logic [2:0] {
    e_app_write = 3'b000,
    e_app_read  = 3'b001
  } app_cmd_e;

  // Default geometry: a 512-bit cache block carried as 8 x 64-bit beats.
  localparam int xui_addr_width_gp    = 28;
  localparam int xui_data_width_gp    = 64;
  localparam int xui_burst_len_gp     = 8;
  localparam int xui_mem_els_gp       = 4096;
  localparam int xui_read_latency_gp  = 4;
  localparam int xui_init_cycles_gp   = 16;

  // Larger of two sizing constants; used to share one counter between the
  // calibration delay and the read-latency countdown.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : bp_xui_mem_pkg

// File: rtl/bp_xui_mem_storage.sv
// ---------------------------------------------------------------------------
// bp_xui_mem_storage
//   Single-port synchronous RAM with per-byte write enables, shaped like
//   bsg_mem_1rw_sync_mask_write_byte. One access per cycle: write when
//   v_i & w_i, read when v_i & ~w_i. Read data appears one cycle after the
//   read request and holds until the next read (writes leave it untouched).
//
// Ports
//   clk_i         clock
//   reset_n_i     async active-low reset (clears the read-data register only)
//   v_i           access valid
//   w_i           1 = write, 0 = read
//   addr_i        word index
//   data_i        write data
//   write_mask_i  per-byte write enable, 1 = byte written
//   data_o        registered read data
// ---------------------------------------------------------------------------
module bp_xui_mem_storage #(
  parameter int els_p   = 4096,
  parameter int width_p = 64,

  localparam int addr_width_lp = $clog2(els_p),
  localparam int mask_width_lp = width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [addr_width_lp-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [mask_width_lp-1:0] write_mask_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] data_q;

  // NOTE: the array has no reset on purpose: contents must survive reset, and
  // a reset on a large array would force it out of RAM into flops.
  always_ff @(posedge clk_i) begin
    if (v_i && w_i) begin
      for (int b = 0; b < mask_width_lp; b++) begin
        if (write_mask_i[b]) begin
          mem_q[addr_i][b*8 +: 8] <= data_i[b*8 +: 8];
        end
      end
    end
  end

  // NOTE: sequential state is assigned with non-blocking (<=) so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_q <= '0;
    end else if (v_i && !w_i) begin
      data_q <= mem_q[addr_i];
    end
  end

  assign data_o = data_q;

endmodule : bp_xui_mem_storage

// File: rtl/bp_xui_mem.sv
// ---------------------------------------------------------------------------
// bp_xui_mem
//   Behavioural backing store speaking the Xilinx-style app_* user interface.
//   Models a calibration delay after reset, then serves one burst command at
//   a time: a write collects burst_len_p byte-masked beats, a read streams
//   burst_len_p beats starting read_latency_p cycles after the command.
//   Addresses wrap silently modulo the storage depth.
//
// Ports
//   clk_i, reset_n_i          clock, async active-low reset
//   app_addr_i/cmd_i/en_i     command byte address, opcode, valid
//   app_rdy_o                 command ready (only while idle)
//   app_wdf_wren_i/data_i     write beat valid / data
//   app_wdf_mask_i            byte mask, 1 = byte NOT written
//   app_wdf_end_i             marks the last write beat
//   app_wdf_rdy_o             write beat ready (only inside a write burst)
//   app_rd_data_valid_o/_o    read beat valid / data (no backpressure)
//   app_rd_data_end_o         last read beat
//   init_calib_complete_o     calibration delay elapsed
//   error_o                   sticky protocol error
// ---------------------------------------------------------------------------
module bp_xui_mem
  import bp_xui_mem_pkg::*;
#(
  parameter int ui_addr_width_p = xui_addr_width_gp,
  parameter int ui_data_width_p = xui_data_width_gp,
  parameter int burst_len_p     = xui_burst_len_gp,
  parameter int mem_els_p       = xui_mem_els_gp,
  parameter int read_latency_p  = xui_read_latency_gp,
  parameter int init_cycles_p   = xui_init_cycles_gp,

  localparam int mask_width_lp = ui_data_width_p / 8
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,

  input  logic [ui_addr_width_p-1:0] app_addr_i,
  input  logic [2:0]                 app_cmd_i,
  input  logic                       app_en_i,
  output logic                       app_rdy_o,

  input  logic                       app_wdf_wren_i,
  input  logic [ui_data_width_p-1:0] app_wdf_data_i,
  input  logic [mask_width_lp-1:0]   app_wdf_mask_i,
  input  logic                       app_wdf_end_i,
  output logic                       app_wdf_rdy_o,

  output logic                       app_rd_data_valid_o,
  output logic [ui_data_width_p-1:0] app_rd_data_o,
  output logic                       app_rd_data_end_o,

  output logic                       init_calib_complete_o,
  output logic                       error_o
);

  localparam int byte_off_lp   = $clog2(mask_width_lp);
  localparam int idx_width_lp  = $clog2(mem_els_p);
  localparam int beat_width_lp = $clog2(burst_len_p);
  localparam int cnt_width_lp  = $clog2(max_int(init_cycles_p, read_latency_p) + 1);

  localparam logic [beat_width_lp-1:0] last_beat_lp = beat_width_lp'(burst_len_p - 1);

  typedef enum logic [2:0] {
    e_init,
    e_idle,
    e_wr_data,
    e_rd_wait,
    e_rd_data
  } state_e;

  state_e                    state_q,  state_d;
  logic [cnt_width_lp-1:0]   cnt_q,    cnt_d;
  logic [beat_width_lp-1:0]  beat_q,   beat_d;
  logic [idx_width_lp-1:0]   base_q,   base_d;
  logic                      error_q,  error_d;

  logic                      mem_v;
  logic                      mem_w;
  logic [beat_width_lp-1:0]  mem_beat;
  logic [idx_width_lp-1:0]   mem_addr;
  logic [idx_width_lp-1:0]   cmd_base;
  logic                      last_beat;

  // Beat index of the command, aligned down to a burst boundary. Address
  // bits above the storage depth are simply dropped, so addresses alias.
  assign cmd_base  = app_addr_i[byte_off_lp +: idx_width_lp]
                   & ~idx_width_lp'(burst_len_p - 1);
  assign last_beat = (beat_q == last_beat_lp);

  // Base is burst aligned, so the add never carries out of the burst; the
  // fixed width gives the modulo-depth wrap for free.
  assign mem_addr  = base_q + idx_width_lp'(mem_beat);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d             = state_q;
    cnt_d               = cnt_q;
    beat_d              = beat_q;
    base_d              = base_q;
    error_d             = error_q;
    mem_v               = 1'b0;
    mem_w               = 1'b0;
    mem_beat            = beat_q;
    app_rdy_o           = 1'b0;
    app_wdf_rdy_o       = 1'b0;
    app_rd_data_valid_o = 1'b0;
    app_rd_data_end_o   = 1'b0;

    case (state_q)
      // Calibration delay: idle is entered on edge init_cycles_p after
      // reset release, since the counter leaves zero on edge 0.
      e_init: begin
        if (cnt_q == cnt_width_lp'(init_cycles_p)) begin
          state_d = e_idle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      e_idle: begin
        app_rdy_o = 1'b1;
        if (app_en_i) begin
          base_d = cmd_base;
          beat_d = '0;
          cnt_d  = '0;
          if (app_cmd_i == e_app_write) begin
            state_d = e_wr_data;
          end else if (app_cmd_i == e_app_read) begin
            state_d = e_rd_wait;
          end else begin
            // Unknown opcode: consumed silently, flagged, no response.
            error_d = 1'b1;
          end
        end
      end

      e_wr_data: begin
        app_wdf_rdy_o = 1'b1;
        if (app_wdf_wren_i) begin
          mem_v = 1'b1;
          mem_w = 1'b1;
          if (app_wdf_end_i != last_beat) begin
            error_d = 1'b1;
          end
          // The beat count, not app_wdf_end_i, closes the burst.
          if (last_beat) begin
            state_d = e_idle;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end

      // The storage read of beat 0 is issued in the final wait cycle so its
      // one-cycle read delay lands exactly on the first data cycle.
      e_rd_wait: begin
        if (cnt_q == cnt_width_lp'(read_latency_p - 1)) begin
          mem_v    = 1'b1;
          mem_beat = '0;
          state_d  = e_rd_data;
          beat_d   = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // beat_q is the beat currently on app_rd_data_o; the storage is
      // already fetching the following one.
      e_rd_data: begin
        app_rd_data_valid_o = 1'b1;
        app_rd_data_end_o   = last_beat;
        if (last_beat) begin
          state_d = e_idle;
        end else begin
          mem_v    = 1'b1;
          mem_beat = beat_q + 1'b1;
          beat_d   = beat_q + 1'b1;
        end
      end

      default: state_d = e_init;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= e_init;
      cnt_q   <= '0;
      beat_q  <= '0;
      base_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      error_q <= error_d;
    end
  end

  // The state register never returns to e_init except through reset, so
  // this is sticky until the next reset.
  assign init_calib_complete_o = (state_q != e_init);
  assign error_o               = error_q;

  // Storage takes a write-enable mask; the XUI mask is a "do not write" mask.
  bp_xui_mem_storage #(
    .els_p   (mem_els_p),
    .width_p (ui_data_width_p)
  ) u_storage (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .v_i          (mem_v),
    .w_i          (mem_w),
    .addr_i       (mem_addr),
    .data_i       (app_wdf_data_i),
    .write_mask_i (~app_wdf_mask_i),
    .data_o       (app_rd_data_o)
  );

endmodule : bp_xui_mem
